// File: rtl/lanes_to_word_pkg.sv
// Shared constants and helpers for the lane-to-word packer.
package lanes_to_word_pkg;

  // Natural byte width; default output word size of the packer.
  localparam int BYTE_LEN = 8;

  // Physical lane position for the cnt-th lane of a word.
  function automatic int lane_index(input int cnt, input int ratio, input bit msb_first);
    if (msb_first) begin
      return ratio - 1 - cnt;
    end else begin
      return cnt;
    end
  endfunction

endpackage

// File: rtl/lanes_to_word.sv
// Narrow-to-wide stream packer: gathers IN_WIDTH-bit lanes into OUT_WIDTH-bit
// words with valid/ready on both sides. A frame end (in_last) flushes a short
// word tagged with its lane count and a last flag.
module lanes_to_word
  import lanes_to_word_pkg::*;
#(
  parameter int IN_WIDTH  = 2,
  parameter int OUT_WIDTH = BYTE_LEN,
  parameter bit MSB_FIRST = 1'b0
) (
  input  logic                                          clk,
  input  logic                                          reset_n,
  input  logic [IN_WIDTH-1:0]                           in_data,
  input  logic                                          in_valid,
  input  logic                                          in_last,
  output logic                                          in_ready,
  output logic [OUT_WIDTH-1:0]                          out_data,
  output logic [$clog2(OUT_WIDTH/IN_WIDTH+1)-1:0]       out_lanes,
  output logic                                          out_last,
  output logic                                          out_valid,
  input  logic                                          out_ready
);

  localparam int RATIO = OUT_WIDTH / IN_WIDTH;
  localparam int CNT_W = $clog2(RATIO + 1);

  // A word must hold a whole number of lanes.
  if ((OUT_WIDTH % IN_WIDTH) != 0 || RATIO < 1) begin : g_bad_ratio
    $error("lanes_to_word: OUT_WIDTH must be a non-zero multiple of IN_WIDTH");
  end

  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [OUT_WIDTH-1:0] asm_q, asm_d;
  logic [OUT_WIDTH-1:0] out_data_q, out_data_d;
  logic [CNT_W-1:0]     out_lanes_q, out_lanes_d;
  logic                 out_last_q, out_last_d;
  logic                 out_valid_q, out_valid_d;

  logic [OUT_WIDTH-1:0] merged_s;
  logic                 accept_s;
  logic                 emit_s;
  int                   idx_s;

  // Ready depends only on the output register and out_ready, never on in_*.
  assign in_ready = !out_valid_q || out_ready;
  assign accept_s = in_valid && in_ready;
  assign emit_s   = (cnt_q == CNT_W'(RATIO - 1)) || in_last;

  // Drop the incoming lane into its slot of the assembly word.
  always_comb begin
    idx_s    = lane_index(int'(cnt_q), RATIO, MSB_FIRST);
    merged_s = asm_q;
    for (int l = 0; l < RATIO; l++) begin
      if (l == idx_s) begin
        merged_s[l*IN_WIDTH +: IN_WIDTH] = in_data;
      end else begin
        merged_s[l*IN_WIDTH +: IN_WIDTH] = asm_q[l*IN_WIDTH +: IN_WIDTH];
      end
    end
  end

  // Next-state: accumulate lanes, emit full/last words, drain the output.
  always_comb begin
    cnt_d       = cnt_q;
    asm_d       = asm_q;
    out_data_d  = out_data_q;
    out_lanes_d = out_lanes_q;
    out_last_d  = out_last_q;
    out_valid_d = out_valid_q;
    // A taken word frees the output; a same-cycle emit below refills it.
    if (out_valid_q && out_ready) begin
      out_valid_d = 1'b0;
    end else begin
      out_valid_d = out_valid_q;
    end
    if (accept_s) begin
      if (emit_s) begin
        out_data_d  = merged_s;
        out_lanes_d = cnt_q + CNT_W'(1);
        out_last_d  = in_last;
        out_valid_d = 1'b1;
        cnt_d       = '0;
        asm_d       = '0;
      end else begin
        asm_d = merged_s;
        cnt_d = cnt_q + CNT_W'(1);
      end
    end else begin
      cnt_d = cnt_q;
      asm_d = asm_q;
    end
  end

  // State and output registers; reset discards partial and pending words.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q       <= '0;
      asm_q       <= '0;
      out_data_q  <= '0;
      out_lanes_q <= '0;
      out_last_q  <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      cnt_q       <= cnt_d;
      asm_q       <= asm_d;
      out_data_q  <= out_data_d;
      out_lanes_q <= out_lanes_d;
      out_last_q  <= out_last_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign out_data  = out_data_q;
  assign out_lanes = out_lanes_q;
  assign out_last  = out_last_q;
  assign out_valid = out_valid_q;

endmodule
